// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the CPU-side port of the data RAM between the CPU
// and a block-fill engine that writes one value over an address range.
// CPU accesses pass straight through. The engine writes only in cycles where
// the CPU leaves the port idle.
// Optional macro RAM_ARB_STARVE_GUARD_EN adds a starvation guard. After the
// engine has been denied MAX_WAIT consecutive cycles, the guard forces one
// engine slot and stalls the CPU for that cycle.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  CLK_50,
    input  logic                  resetN,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH:0]   fill_len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [7:0]            WAIT_LIMIT = 8'(MAX_WAIT);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   eff_len;
    logic [DATA_WIDTH-1:0] value;
    logic                  eng_grant;
    logic                  force_slot;

    // A fill longer than the whole address space is clamped to one full pass.
    assign eff_len = (fill_len > FULL_LEN) ? FULL_LEN : fill_len;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic [7:0] wait_cnt;

    assign force_slot = (state == FILL) && (wait_cnt == WAIT_LIMIT);

    // Count consecutive denied fill cycles. Any grant or leaving FILL restarts the count.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN)
            wait_cnt <= '0;
        else if (state == FILL && !eng_grant)
            wait_cnt <= wait_cnt + 8'd1;
        else
            wait_cnt <= '0;
    end
`else
    logic unused_max_wait;

    assign force_slot      = 1'b0;
    assign unused_max_wait = ^WAIT_LIMIT;
`endif

    assign eng_grant = (state == FILL) && (!cpu_req || force_slot);

    // Port mux. A forced slot overrides the CPU, so its write is dropped for that cycle.
    assign ram_addr  = eng_grant ? ptr   : cpu_addr;
    assign ram_wdata = eng_grant ? value : cpu_wdata;
    assign ram_we    = resetN & (eng_grant | (cpu_req & cpu_we));
    assign cpu_stall = force_slot;
    assign cpu_rdata = ram_rdata;
    assign fill_busy = (state != IDLE);
    assign fill_done = (state == DONE);

    // State register.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. A start request outside IDLE is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fill_start) state_nxt = (eff_len != '0) ? FILL : DONE;
            FILL: if (eng_grant && remaining == LEN_ONE) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill datapath. Latch the job on start, then advance the pointer on each granted write.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            ptr       <= '0;
            remaining <= '0;
            value     <= '0;
        end else if (state == IDLE && fill_start) begin
            ptr       <= fill_base;
            remaining <= eff_len;
            value     <= fill_value;
        end else if (eng_grant) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - LEN_ONE;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter. The bench holds a behavioural RAM
// and a cycle-level reference model of the fill job, built from the grant rules.
// The bench also reads RAM_ARB_STARVE_GUARD_EN, so it can check either build.
module tb_ram_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int MW    = 8;
    localparam int DEPTH = 4096;
`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          CLK_50 = 1'b0;
    logic          resetN;
    logic          cpu_req, cpu_we, fill_start;
    logic [AW-1:0] cpu_addr, fill_base;
    logic [DW-1:0] cpu_wdata, fill_value;
    logic [AW:0]   fill_len;
    logic [DW-1:0] cpu_rdata, ram_wdata, ram_rdata;
    logic          cpu_stall, fill_busy, fill_done, ram_we;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: 0 idle, 1 filling, 2 done.
    int            m_state, m_ptr, m_left, m_wait;
    logic [DW-1:0] m_val;
    bit            m_grant;

    // Observations from the most recent cycle.
    logic          o_we, o_stall, o_done, o_busy;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .CLK_50(CLK_50), .resetN(resetN),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 CLK_50 = ~CLK_50;

    // Synchronous-read RAM behind the arbiter.
    always @(posedge CLK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle. Check at the negedge against the model, then advance the model at the posedge.
    task automatic step();
        bit            exp_we, exp_stall;
        int            exp_addr;
        logic [DW-1:0] exp_wd;
        @(negedge CLK_50);
        if (!resetN) begin
            m_state = 0; m_wait = 0; m_ptr = 0; m_left = 0;
        end
        m_grant   = (m_state == 1) && (!cpu_req || (GUARD && m_wait == MW));
        exp_stall = GUARD && (m_state == 1) && (m_wait == MW);
        exp_we    = resetN && (m_grant || (cpu_req && cpu_we));
        exp_addr  = m_grant ? m_ptr : int'(cpu_addr);
        exp_wd    = m_grant ? m_val : cpu_wdata;
        chk("ram_we",    32'(ram_we),    32'(exp_we));
        chk("ram_addr",  32'(ram_addr),  exp_addr);
        chk("ram_wdata", 32'(ram_wdata), 32'(exp_wd));
        chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        chk("fill_busy", 32'(fill_busy), 32'(m_state != 0));
        chk("fill_done", 32'(fill_done), 32'(m_state == 2));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(ram_rdata));
        o_we = ram_we; o_stall = cpu_stall; o_done = fill_done; o_busy = fill_busy;
        o_addr = ram_addr; o_wdata = ram_wdata;
        @(posedge CLK_50);
        if (resetN) begin
            case (m_state)
                0: if (fill_start) begin
                    int len;
                    len = int'(fill_len);
                    if (len > DEPTH) len = DEPTH;
                    m_ptr = int'(fill_base); m_left = len; m_val = fill_value; m_wait = 0;
                    m_state = (len != 0) ? 1 : 2;
                end
                1: if (m_grant) begin
                    m_ptr = (m_ptr + 1) % DEPTH;
                    m_left--;
                    m_wait = 0;
                    if (m_left == 0) m_state = 2;
                end else begin
                    m_wait++;
                end
                default: m_state = 0;
            endcase
        end else begin
            m_state = 0; m_wait = 0;
        end
        #1;
    endtask

    // Present a start request for one cycle (cycle 0 of the fill).
    task automatic start_fill(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] v);
        fill_start = 1'b1; fill_base = b; fill_len = l; fill_value = v;
        step();
        fill_start = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] wrap_addr [4];
        int cnt, cyc, nstall;
        bit seen;
        wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF; wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;
        m_state = 0; m_ptr = 0; m_left = 0; m_wait = 0; m_val = '0;
        resetN = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0AB; cpu_wdata = 16'h1357;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
        #1;
        repeat (2) step();
        chk("rst_ram_we", 32'(o_we), 0);
        chk("rst_addr", 32'(o_addr), 32'h0AB);
        resetN = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        step();

        // CPU passthrough while idle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 16'hBEEF;
        step();
        chk("pt_we", 32'(o_we), 1);
        chk("pt_addr", 32'(o_addr), 32'h123);
        chk("pt_wdata", 32'(o_wdata), 32'hBEEF);
        chk("pt_stall", 32'(o_stall), 0);
        cpu_we = 1'b0;
        step();
        chk("pt_read", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 1'b0;

        // Fill with an idle CPU
        start_fill(12'h010, 13'd4, 16'hAAAA);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("idle_we", 32'(o_we), 32'(c <= 4));
            if (c <= 4) begin
                chk("idle_addr", 32'(o_addr), 32'h010 + 32'(c - 1));
                chk("idle_wdata", 32'(o_wdata), 32'hAAAA);
            end
            chk("idle_done", 32'(o_done), 32'(c == 5));
            chk("idle_busy", 32'(o_busy), 1);
        end
        step();
        chk("idle_busy_end", 32'(o_busy), 0);
        chk("idle_mem", 32'(mem[12'h013]), 32'hAAAA);

        // Contention under a continuous CPU request
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h777;
        if (GUARD) begin
            start_fill(12'h200, 13'd2, 16'h5555);
            for (int c = 1; c <= 19; c++) begin
                step();
                chk("cont_we", 32'(o_we), 32'(c == 9 || c == 18));
                chk("cont_stall", 32'(o_stall), 32'(c == 9 || c == 18));
                chk("cont_done", 32'(o_done), 32'(c == 19));
            end
            cpu_req = 1'b0;
            step();
        end else begin
            start_fill(12'h300, 13'd3, 16'h1234);
            cnt = 0; nstall = 0;
            repeat (100) begin
                step();
                if (o_we) cnt++;
                if (o_stall) nstall++;
            end
            chk("starve_we", 32'(cnt), 0);
            chk("starve_stall", 32'(nstall), 0);
            chk("starve_busy", 32'(o_busy), 1);
            cpu_req = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                step();
                chk("resume_we", 32'(o_we), 32'(c <= 3));
                chk("resume_done", 32'(o_done), 32'(c == 4));
            end
        end

        // Address wrap past the top of the RAM
        start_fill(12'hFFE, 13'd4, 16'h0F0F);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("wrap_we", 32'(o_we), 1);
            chk("wrap_addr", 32'(o_addr), 32'(wrap_addr[c]));
        end
        step();
        chk("wrap_done", 32'(o_done), 1);

        // Oversized length is clamped to one full pass
        start_fill(12'h055, 13'h1FFF, 16'h7777);
        cnt = 0; cyc = 0;
        do begin
            step();
            cyc++;
            if (o_we) cnt++;
        end while (!o_done && cyc < 5000);
        chk("clamp_done_seen", 32'(o_done), 1);
        chk("clamp_writes", 32'(cnt), 32'd4096);
        chk("clamp_cycles", 32'(cyc), 32'd4097);

        // Zero length goes straight to DONE
        start_fill(12'h100, 13'd0, 16'h9999);
        step();
        chk("zero_done", 32'(o_done), 1);
        chk("zero_busy", 32'(o_busy), 1);
        chk("zero_we", 32'(o_we), 0);
        step();
        chk("zero_busy_end", 32'(o_busy), 0);

        // Reset in the middle of a fill
        start_fill(12'h400, 13'd8, 16'h3C3C);
        repeat (2) begin
            step();
            chk("mid_we", 32'(o_we), 1);
        end
        resetN = 1'b0; cpu_addr = 12'h0AB;
        #1;
        chk("mid_busy_async", 32'(fill_busy), 0);
        step();
        chk("mid_rst_we", 32'(o_we), 0);
        chk("mid_rst_addr", 32'(o_addr), 32'h0AB);
        resetN = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (o_done) seen = 1'b1;
        end
        chk("mid_no_done", 32'(seen), 0);
        chk("mid_mem_kept", 32'(mem[12'h401]), 32'h3C3C);

        // A start request during DONE is ignored
        start_fill(12'h500, 13'd1, 16'h1111);
        step();
        chk("dn_we", 32'(o_we), 1);
        fill_start = 1'b1; fill_base = 12'h600; fill_len = 13'd3;
        step();
        chk("dn_done", 32'(o_done), 1);
        fill_start = 1'b0;
        step();
        chk("dn_ignored_busy", 32'(o_busy), 0);
        chk("dn_ignored_we", 32'(o_we), 0);

        // Random traffic checked against the model
        for (int i = 0; i < 2000; i++) begin
            cpu_req    = ($urandom_range(0, 99) < 60);
            cpu_we     = $urandom_range(0, 1) == 1;
            cpu_addr   = AW'($urandom);
            cpu_wdata  = DW'($urandom);
            fill_start = ($urandom_range(0, 7) == 0);
            fill_base  = AW'($urandom);
            fill_len   = 13'($urandom_range(0, 10));
            fill_value = DW'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
